// File: rtl/rasterizer_pkg.sv
// Shared rasterizer definitions: traversal FSM states and default datapath widths.
package rasterizer_pkg;

  // Pixel coordinates are signed so that guard-band boxes may start left of / above the origin.
  localparam int DEFAULT_COORD_WIDTH = 10;

  // Edge functions are products of two coordinate differences plus a sign bit and a carry bit.
  localparam int DEFAULT_EDGE_WIDTH = 2 * DEFAULT_COORD_WIDTH + 2;

  // Traversal states: waiting for a job, walking the box, signalling job completion.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } trav_state_e;

endpackage : rasterizer_pkg

// File: rtl/edge_stepper.sv
// Incremental evaluator for one triangle edge function over a row-major box walk.
// Holds the value at the current candidate and at the start of the current row, so
// a row change never needs to undo the accumulated x-steps.
module edge_stepper
  import rasterizer_pkg::*;
#(
  parameter int EDGE_WIDTH = DEFAULT_EDGE_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         step_x,
  input  logic                         step_row,
  input  logic signed [EDGE_WIDTH-1:0] init_val,
  input  logic signed [EDGE_WIDTH-1:0] dx,
  input  logic signed [EDGE_WIDTH-1:0] dy,
  output logic signed [EDGE_WIDTH-1:0] e
);

  logic signed [EDGE_WIDTH-1:0] e_q, e_d;
  logic signed [EDGE_WIDTH-1:0] row_e_q, row_e_d;
  logic signed [EDGE_WIDTH-1:0] dx_q, dx_d;
  logic signed [EDGE_WIDTH-1:0] dy_q, dy_d;
  logic signed [EDGE_WIDTH-1:0] next_row_e;

  // The next row's start value feeds both the row register and the candidate value.
  assign next_row_e = row_e_q + dy_q;

  // Choose between loading a new job, stepping along x, and dropping to the next row.
  always_comb begin
    e_d     = e_q;
    row_e_d = row_e_q;
    dx_d    = dx_q;
    dy_d    = dy_q;
    if (load) begin
      e_d     = init_val;
      row_e_d = init_val;
      dx_d    = dx;
      dy_d    = dy;
    end else if (step_x) begin
      e_d = e_q + dx_q;
    end else if (step_row) begin
      row_e_d = next_row_e;
      e_d     = next_row_e;
    end
  end

  // Edge state registers, cleared by synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      e_q     <= '0;
      row_e_q <= '0;
      dx_q    <= '0;
      dy_q    <= '0;
    end else begin
      e_q     <= e_d;
      row_e_q <= row_e_d;
      dx_q    <= dx_d;
      dy_q    <= dy_d;
    end
  end

  assign e = e_q;

endmodule : edge_stepper

// File: rtl/bbox_traversal.sv
// Bounding-box traversal: walks a triangle's clamped box in row-major order, one
// candidate pixel per cycle, and presents the covered pixels with their edge values.
module bbox_traversal
  import rasterizer_pkg::*;
#(
  parameter int COORD_WIDTH = DEFAULT_COORD_WIDTH,
  parameter int EDGE_WIDTH  = 2 * COORD_WIDTH + 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [COORD_WIDTH-1:0] min_x,
  input  logic signed [COORD_WIDTH-1:0] max_x,
  input  logic signed [COORD_WIDTH-1:0] min_y,
  input  logic signed [COORD_WIDTH-1:0] max_y,
  input  logic                          bbox_valid,
  input  logic signed [EDGE_WIDTH-1:0]  e0_init,
  input  logic signed [EDGE_WIDTH-1:0]  e1_init,
  input  logic signed [EDGE_WIDTH-1:0]  e2_init,
  input  logic signed [EDGE_WIDTH-1:0]  e0_dx,
  input  logic signed [EDGE_WIDTH-1:0]  e1_dx,
  input  logic signed [EDGE_WIDTH-1:0]  e2_dx,
  input  logic signed [EDGE_WIDTH-1:0]  e0_dy,
  input  logic signed [EDGE_WIDTH-1:0]  e1_dy,
  input  logic signed [EDGE_WIDTH-1:0]  e2_dy,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [COORD_WIDTH-1:0] out_x,
  output logic signed [COORD_WIDTH-1:0] out_y,
  output logic signed [EDGE_WIDTH-1:0]  out_e0,
  output logic signed [EDGE_WIDTH-1:0]  out_e1,
  output logic signed [EDGE_WIDTH-1:0]  out_e2,
  output logic                          done
);

  trav_state_e state_q, state_d;

  logic signed [COORD_WIDTH-1:0] cx_q, cx_d;
  logic signed [COORD_WIDTH-1:0] cy_q, cy_d;
  logic signed [COORD_WIDTH-1:0] min_x_q, min_x_d;
  logic signed [COORD_WIDTH-1:0] max_x_q, max_x_d;
  logic signed [COORD_WIDTH-1:0] max_y_q, max_y_d;

  logic load;
  logic step_x;
  logic step_row;
  logic covered;

  logic signed [EDGE_WIDTH-1:0] e0;
  logic signed [EDGE_WIDTH-1:0] e1;
  logic signed [EDGE_WIDTH-1:0] e2;

  // One stepper per triangle edge; all three move in lockstep with the coordinates.
  edge_stepper #(
    .EDGE_WIDTH (EDGE_WIDTH)
  ) u_edge0 (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step_x   (step_x),
    .step_row (step_row),
    .init_val (e0_init),
    .dx       (e0_dx),
    .dy       (e0_dy),
    .e        (e0)
  );

  edge_stepper #(
    .EDGE_WIDTH (EDGE_WIDTH)
  ) u_edge1 (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step_x   (step_x),
    .step_row (step_row),
    .init_val (e1_init),
    .dx       (e1_dx),
    .dy       (e1_dy),
    .e        (e1)
  );

  edge_stepper #(
    .EDGE_WIDTH (EDGE_WIDTH)
  ) u_edge2 (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step_x   (step_x),
    .step_row (step_row),
    .init_val (e2_init),
    .dx       (e2_dx),
    .dy       (e2_dy),
    .e        (e2)
  );

  // A pixel is inside when it lies on the non-negative side of all three edges.
  assign covered = (e0 >= 0) && (e1 >= 0) && (e2 >= 0);

  // Next-state, coordinate advance and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cx_d      = cx_q;
    cy_d      = cy_q;
    min_x_d   = min_x_q;
    max_x_d   = max_x_q;
    max_y_d   = max_y_q;
    load      = 1'b0;
    step_x    = 1'b0;
    step_row  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (bbox_valid) begin
            load    = 1'b1;
            cx_d    = min_x;
            cy_d    = min_y;
            min_x_d = min_x;
            max_x_d = max_x;
            max_y_d = max_y;
            state_d = SCAN;
          end else begin
            state_d = DONE;
          end
        end
      end
      SCAN: begin
        out_valid = covered;
        if (!covered || out_ready) begin
          if (cx_q < max_x_q) begin
            step_x = 1'b1;
            cx_d   = cx_q + COORD_WIDTH'(1);
          end else if (cy_q < max_y_q) begin
            step_row = 1'b1;
            cx_d     = min_x_q;
            cy_d     = cy_q + COORD_WIDTH'(1);
          end else begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and coordinate registers; reset abandons any job in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      min_x_q <= '0;
      max_x_q <= '0;
      max_y_q <= '0;
    end else begin
      state_q <= state_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      min_x_q <= min_x_d;
      max_x_q <= max_x_d;
      max_y_q <= max_y_d;
    end
  end

  assign out_x  = cx_q;
  assign out_y  = cy_q;
  assign out_e0 = e0;
  assign out_e1 = e1;
  assign out_e2 = e2;

endmodule : bbox_traversal

// File: doc/bbox_traversal.md
BBOX_TRAVERSAL -- requirements
Module: bbox_traversal

Interface
REQ-001 The module SHALL have parameter COORD_WIDTH, default 10, giving the signed pixel coordinate width.
REQ-002 The module SHALL have parameter EDGE_WIDTH, default 2*COORD_WIDTH+2, giving the signed edge-function width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The module SHALL have port in_valid, input, 1 bit: the triangle-job offer.
REQ-006 The module SHALL have port in_ready, output, 1 bit: the block accepts a job.
REQ-007 The module SHALL have ports min_x, max_x, min_y, max_y, input, COORD_WIDTH signed each: the clamped bounding box, with max inclusive.
REQ-008 The module SHALL have port bbox_valid, input, 1 bit: the box is non-empty.
REQ-009 The module SHALL have ports e0_init, e1_init, e2_init, input, EDGE_WIDTH signed each: the edge-function values at (min_x, min_y).
REQ-010 The module SHALL have ports e0_dx, e1_dx, e2_dx and e0_dy, e1_dy, e2_dy, input, EDGE_WIDTH signed each: the per-edge increments for +1 x and +1 y.
REQ-011 The module SHALL have port out_valid, output, 1 bit: a covered pixel is presented.
REQ-012 The module SHALL have port out_ready, input, 1 bit: downstream accepts the pixel.
REQ-013 The module SHALL have ports out_x and out_y, output, COORD_WIDTH signed each: the pixel coordinates.
REQ-014 The module SHALL have ports out_e0, out_e1, out_e2, output, EDGE_WIDTH signed each: the edge values at the pixel, used for barycentrics.
REQ-015 The module SHALL have port done, output, 1 bit: a one-cycle pulse marking the end of a job.

Function
REQ-016 The module SHALL implement FSM states IDLE, SCAN and DONE.
REQ-017 In_ready SHALL equal 1 only in IDLE; a job SHALL be accepted on a cycle with in_valid && in_ready.
REQ-018 On acceptance with bbox_valid=1, the block SHALL load cx=min_x, cy=min_y, e_i=row_e_i=ei_init, latch the bounds and increments, and enter SCAN.
REQ-019 On acceptance with bbox_valid=0, the block SHALL enter DONE directly and emit no pixel.
REQ-020 In SCAN, covered SHALL be (e0>=0)&&(e1>=0)&&(e2>=0), and out_valid SHALL equal covered.
REQ-021 Out_x, out_y and out_eN SHALL be driven from the candidate registers.
REQ-022 The candidate SHALL advance when !covered || out_ready; an uncovered candidate SHALL consume exactly one cycle.
REQ-023 While out_valid=1 && out_ready=0, all outputs SHALL hold stable.
REQ-024 The advance order SHALL be row-major: if cx<max_x then cx+=1 and e_i+=ei_dx; else if cy<max_y then cx=min_x, cy+=1, row_e_i+=ei_dy and e_i=row_e_i+ei_dy; else go to DONE.
REQ-025 The first candidate SHALL be visible in the cycle after acceptance; with out_ready held at 1, one candidate SHALL be processed per cycle, so (W*H) SCAN cycles per job.
REQ-026 In DONE, done SHALL equal 1 for exactly one cycle and the next state SHALL be IDLE; done SHALL be 0 in all other states.
REQ-027 Edge arithmetic SHALL be EDGE_WIDTH two's complement, wrapping modulo 2^EDGE_WIDTH; upstream guarantees no overflow.
REQ-028 Coordinates SHALL not exceed max_x/max_y, and no x/y wrap SHALL be possible.
REQ-029 Input fields SHALL be sampled only on acceptance; input changes during SCAN SHALL have no effect.

Reset
REQ-030 When rst=1 at a clock edge, the state SHALL become IDLE regardless of the current state, abandoning any job in flight.
REQ-031 After reset, out_valid SHALL be 0, done SHALL be 0 and in_ready SHALL be 1.
REQ-032 After reset, out_x, out_y and out_eN SHALL be 0.
REQ-033 A job interrupted by reset SHALL produce no done pulse.

Structure
REQ-034 The FSM state enum and default widths SHALL live in the shared rasterizer_pkg.
REQ-035 The design SHALL have one sub-module, edge_stepper, instantiated three times; each instance SHALL hold e/row_e and perform the x-step and the row-step.

Verification
REQ-036 The bench SHALL cover: box (0..1, 0..1), all ei_init=1, increments 0, out_ready=1 -> pixels (0,0),(1,0),(0,1),(1,1) on 4 consecutive cycles, then done for 1 cycle.
REQ-037 The bench SHALL cover: bbox_valid=0 accepted -> out_valid never 1, done the next cycle, in_ready 1 the cycle after.
REQ-038 The bench SHALL cover: box (0..2, 0..0), e0_init=-1, e0_dx=1, others 5 -> outputs (1,0) with e0=0 and (2,0) with e0=1 only.
REQ-039 The bench SHALL cover: box (0..1, 0..1), e1_init=0, e1_dx=1, e1_dy=2, others 5 -> out_e1 sequence 0,1,2,3.
REQ-040 The bench SHALL cover: out_ready=0 for 3 cycles on first pixel (3,4) -> out_valid=1 and out_x=3, out_y=4 held stable, next pixel follows release.
REQ-041 The bench SHALL cover: rst=1 mid-SCAN -> next cycle IDLE, out_valid=0, in_ready=1, no done.
